sdcard_stream_buffer: RTL

SDCARD_STREAM_BUFFER -- requirements
Module: sdcard_stream_buffer

---
 rtl/sdcard_stream_buffer_pkg.sv | 22 ++
 rtl/sdcard_stream_buffer_sample_fifo.sv | 58 +++++
 rtl/sdcard_stream_buffer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sdcard_stream_buffer_pkg.sv
// rtl/sdcard_stream_buffer_pkg.sv - SD reader constants and stream buffer state encoding
package sdcard_stream_buffer_pkg;

  localparam int SD_BLOCK_ADDR_BITS    = 32;
  localparam int SD_BLOCK_LENGHT_BITS  = 9;
  localparam int SD_BLOCK_LENGHT_BYTES = 512;

  localparam int SAMPLE_BITS    = 16;
  localparam int REFILL_SAMPLES = SD_BLOCK_LENGHT_BYTES / 2;

  localparam logic [SD_BLOCK_LENGHT_BITS-1:0] LAST_BYTE_IDX =
    SD_BLOCK_LENGHT_BITS'(SD_BLOCK_LENGHT_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_STREAM,
    ST_DRAIN,
    ST_WAIT_SPACE
  } state_t;

endpackage

// File: rtl/sdcard_stream_buffer_sample_fifo.sv
// rtl/sdcard_stream_buffer_sample_fifo.sv - first-word-fall-through sample FIFO
module sample_fifo
  import sdcard_stream_buffer_pkg::*;
#(
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [SAMPLE_BITS-1:0] push_data,
  input  logic                   pop,
  output logic [SAMPLE_BITS-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count
);

  logic [SAMPLE_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdcard_stream_buffer.sv
// rtl/sdcard_stream_buffer.sv - streams SD card blocks into a 16-bit sample FIFO
module sdcard_stream_buffer
  import sdcard_stream_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH = 512
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            play_start,
  input  logic                            play_stop,
  input  logic [SD_BLOCK_ADDR_BITS-1:0]   start_block,
  input  logic [15:0]                     num_blocks,
  output logic                            block_read_trigger,
  output logic                            block_read_continous_mode,
  output logic [SD_BLOCK_ADDR_BITS-1:0]   block_read_block_addr,
  input  logic [7:0]                      block_read_data_out,
  input  logic [SD_BLOCK_LENGHT_BITS-1:0] block_read_data_idx,
  input  logic                            block_read_data_new_flag,
  input  logic                            block_read_card_ready,
  output logic [SAMPLE_BITS-1:0]          sample_data,
  output logic                            sample_valid,
  input  logic                            sample_ready,
  output logic                            playing,
  output logic                            underrun,
  output logic                            stream_error
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] SPACE_LIMIT = (CW+1)'(FIFO_DEPTH - REFILL_SAMPLES);

  state_t                        state;
  state_t                        state_nxt;
  logic                          flag_d;
  logic                          ready_d;
  logic                          byte_stb;
  logic                          last_byte;
  logic [7:0]                    lo_byte;
  logic                          have_lo;
  logic                          wr_en;
  logic [SAMPLE_BITS-1:0]        wr_data;
  logic                          blk_end;
  logic [SD_BLOCK_ADDR_BITS-1:0] next_addr;
  logic [SD_BLOCK_ADDR_BITS-1:0] addr_q;
  logic [15:0]                   remaining;
  logic                          stop_pending;
  logic                          err_q;
  logic                          start_ok;
  logic                          reader_fail;
  logic                          overflow;
  logic                          space_ok;
  logic [CW:0]                   used;
  logic [CW-1:0]                 fifo_count;
  logic                          fifo_full;
  logic                          fifo_empty;

  assign byte_stb    = block_read_data_new_flag && !flag_d;
  assign last_byte   = byte_stb && (state == ST_STREAM) && (block_read_data_idx == LAST_BYTE_IDX);
  assign start_ok    = play_start && (state == ST_IDLE) && block_read_card_ready && (num_blocks != '0);
  assign reader_fail = (state == ST_STREAM) && block_read_card_ready && !ready_d && !blk_end;
  assign overflow    = wr_en && fifo_full && !sample_ready;

  // The sample still in the write stage already claims its FIFO slot.
  assign used     = {1'b0, fifo_count} + (CW+1)'(wr_en);
  assign space_ok = (used <= SPACE_LIMIT);

  always_comb begin
    state_nxt          = state;
    block_read_trigger = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_REQUEST;
      end
      ST_REQUEST: begin
        block_read_trigger = 1'b1;
        if (!block_read_card_ready) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        block_read_trigger = 1'b1;
        if (reader_fail) begin
          state_nxt = ST_IDLE;
        end else if (blk_end && ((remaining == '0) || !space_ok || stop_pending)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (block_read_card_ready) begin
          state_nxt = ((remaining == '0) || stop_pending) ? ST_IDLE : ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        if (stop_pending) begin
          state_nxt = ST_IDLE;
        end else if (space_ok) begin
          state_nxt = ST_REQUEST;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      flag_d       <= 1'b0;
      ready_d      <= 1'b0;
      lo_byte      <= '0;
      have_lo      <= 1'b0;
      wr_en        <= 1'b0;
      wr_data      <= '0;
      blk_end      <= 1'b0;
      next_addr    <= '0;
      addr_q       <= '0;
      remaining    <= '0;
      stop_pending <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state   <= state_nxt;
      flag_d  <= block_read_data_new_flag;
      ready_d <= block_read_card_ready;
      wr_en   <= 1'b0;
      blk_end <= last_byte;

      // Even bytes carry the low half; an odd byte completes the sample.
      if (byte_stb) begin
        if (!block_read_data_idx[0]) begin
          lo_byte <= block_read_data_out;
          have_lo <= 1'b1;
        end else begin
          have_lo <= 1'b0;
          if (have_lo) begin
            wr_en   <= 1'b1;
            wr_data <= {block_read_data_out, lo_byte};
          end
        end
      end

      if (start_ok) begin
        next_addr <= start_block;
        addr_q    <= start_block;
        remaining <= num_blocks;
      end else if (last_byte) begin
        next_addr <= next_addr + SD_BLOCK_ADDR_BITS'(1);
        remaining <= remaining - 16'd1;
      end

      if ((state == ST_WAIT_SPACE) && (state_nxt == ST_REQUEST)) begin
        addr_q <= next_addr;
      end

      if (state_nxt == ST_IDLE) begin
        stop_pending <= 1'b0;
      end else if (play_stop) begin
        stop_pending <= 1'b1;
      end

      if (reader_fail || overflow) begin
        err_q <= 1'b1;
      end else if (start_ok) begin
        err_q <= 1'b0;
      end
    end
  end

  sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_sample_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (sample_ready),
    .rd_data   (sample_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign sample_valid              = !fifo_empty;
  assign block_read_continous_mode = block_read_trigger;
  assign block_read_block_addr     = addr_q;
  assign playing                   = (state != ST_IDLE);
  assign underrun                  = playing && sample_ready && !sample_valid;
  assign stream_error              = err_q;

endmodule
